round_scorer: RTL and testbench

ROUND_SCORER -- requirements
Module: round_scorer

---
 rtl/round_scorer.sv | 186 ++++++++++++++++++
 tb/tb_round_scorer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_scorer.sv
// rtl/round_scorer.sv - round/match score keeper for a two-player trail game
// Optional frame-counted post-crash hold enabled by defining ROUND_HOLD_EN.
module round_scorer #(
    parameter int WIN_SCORE   = 3,
    parameter int HOLD_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Reset_Game,
    input  logic [2:0] Game_State,
    input  logic       frame_tick,
    input  logic       Blue_Crash,
    input  logic       Red_Crash,
    output logic       Reset_Round,
    output logic       Blue_W,
    output logic       Red_W,
    output logic [3:0] Blue_Score,
    output logic [3:0] Red_Score,
    output logic [1:0] round_winner
);

    localparam logic [3:0] WIN       = 4'(WIN_SCORE);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_FRAMES);

    localparam logic [2:0] GS_MENU    = 3'd0;
    localparam logic [2:0] GS_STARTED = 3'd2;

    localparam logic [1:0] RW_NONE = 2'd0;
    localparam logic [1:0] RW_BLUE = 2'd1;
    localparam logic [1:0] RW_RED  = 2'd2;
    localparam logic [1:0] RW_DRAW = 2'd3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PLAY       = 2'd1,
        HOLD       = 2'd2,
        MATCH_DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_nxt;

    logic       reset_round_nxt;
    logic       blue_w_nxt;
    logic       red_w_nxt;
    logic [3:0] blue_score_nxt;
    logic [3:0] red_score_nxt;
    logic [1:0] round_winner_nxt;

    logic       clear;
    logic       in_round;
    logic       any_crash;
    logic       hold_done;
    logic       match_blue;
    logic       match_red;
    logic       match_won;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign clear     = Reset_Game || (Game_State == GS_MENU);
    assign in_round  = (Game_State == GS_STARTED);
    assign any_crash = Blue_Crash || Red_Crash;

`ifdef ROUND_HOLD_EN
    // The outcome is issued on the tick that takes the counter to zero.
    assign hold_done = ((hold_cnt == 8'd1) && frame_tick) || (hold_cnt == 8'd0);
`else
    assign hold_done = 1'b1;
`endif

    // If both players sit at the target (scores carried over), the last round's winner takes it.
    assign match_blue = (Blue_Score == WIN) && !((Red_Score == WIN) && (round_winner == RW_RED));
    assign match_red  = (Red_Score == WIN) && !match_blue;
    assign match_won  = match_blue || match_red;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            hold_cnt     <= 8'd0;
            Reset_Round  <= 1'b0;
            Blue_W       <= 1'b0;
            Red_W        <= 1'b0;
            Blue_Score   <= 4'd0;
            Red_Score    <= 4'd0;
            round_winner <= RW_NONE;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_cnt_nxt;
            Reset_Round  <= reset_round_nxt;
            Blue_W       <= blue_w_nxt;
            Red_W        <= red_w_nxt;
            Blue_Score   <= blue_score_nxt;
            Red_Score    <= red_score_nxt;
            round_winner <= round_winner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_round) state_nxt = PLAY;
                end
                PLAY: begin
                    if (!in_round)     state_nxt = IDLE;
                    else if (any_crash) state_nxt = HOLD;
                end
                HOLD: begin
                    if (!in_round)      state_nxt = IDLE;
                    else if (hold_done) state_nxt = match_won ? MATCH_DONE : IDLE;
                end
                MATCH_DONE: begin
                    if (!in_round) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        hold_cnt_nxt     = hold_cnt;
        reset_round_nxt  = 1'b0;
        blue_w_nxt       = Blue_W;
        red_w_nxt        = Red_W;
        blue_score_nxt   = Blue_Score;
        red_score_nxt    = Red_Score;
        round_winner_nxt = round_winner;
        if (clear) begin
            hold_cnt_nxt     = 8'd0;
            blue_w_nxt       = 1'b0;
            red_w_nxt        = 1'b0;
            blue_score_nxt   = 4'd0;
            red_score_nxt    = 4'd0;
            round_winner_nxt = RW_NONE;
        end else begin
            case (state)
                PLAY: begin
                    if (in_round && any_crash) begin
                        hold_cnt_nxt = HOLD_LOAD;
                        if (Blue_Crash && Red_Crash) begin
                            round_winner_nxt = RW_DRAW;
                        end else if (Red_Crash) begin
                            blue_score_nxt   = sat_inc(Blue_Score);
                            round_winner_nxt = RW_BLUE;
                        end else begin
                            red_score_nxt    = sat_inc(Red_Score);
                            round_winner_nxt = RW_RED;
                        end
                    end
                end
                HOLD: begin
                    if (!in_round) begin
                        hold_cnt_nxt = 8'd0;
                    end else if (hold_done) begin
                        hold_cnt_nxt = 8'd0;
                        if (match_won) begin
                            blue_w_nxt = match_blue;
                            red_w_nxt  = match_red;
                        end else begin
                            reset_round_nxt = 1'b1;
                        end
                    end else if (frame_tick && (hold_cnt != 8'd0)) begin
                        hold_cnt_nxt = hold_cnt - 8'd1;
                    end
                end
                MATCH_DONE: begin
                    if (!in_round) begin
                        blue_w_nxt = 1'b0;
                        red_w_nxt  = 1'b0;
                    end
                end
                default: begin
                    hold_cnt_nxt = 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_scorer.sv
// tb/tb_round_scorer.sv - directed self-checking bench for round_scorer
module tb_round_scorer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Reset_Game;
    logic [2:0] Game_State;
    logic       frame_tick;
    logic       Blue_Crash;
    logic       Red_Crash;

    logic       Reset_Round, Blue_W, Red_W;
    logic [3:0] Blue_Score, Red_Score;
    logic [1:0] round_winner;

    logic       rr15, bw15, rw15;
    logic [3:0] bs15, rs15;
    logic [1:0] win15;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ROUND_HOLD_EN
    localparam int EXP_POS = 3;
`else
    localparam int EXP_POS = 1;
`endif

    always #5 Clk = ~Clk;

    round_scorer #(.WIN_SCORE(3), .HOLD_FRAMES(2)) u_dut (
        .Clk(Clk), .Reset(Reset), .Reset_Game(Reset_Game), .Game_State(Game_State),
        .frame_tick(frame_tick), .Blue_Crash(Blue_Crash), .Red_Crash(Red_Crash),
        .Reset_Round(Reset_Round), .Blue_W(Blue_W), .Red_W(Red_W),
        .Blue_Score(Blue_Score), .Red_Score(Red_Score), .round_winner(round_winner)
    );

    round_scorer #(.WIN_SCORE(15), .HOLD_FRAMES(2)) u_dut15 (
        .Clk(Clk), .Reset(Reset), .Reset_Game(Reset_Game), .Game_State(Game_State),
        .frame_tick(frame_tick), .Blue_Crash(Blue_Crash), .Red_Crash(Red_Crash),
        .Reset_Round(rr15), .Blue_W(bw15), .Red_W(rw15),
        .Blue_Score(bs15), .Red_Score(rs15), .round_winner(win15)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic crash(input logic b, input logic r);
        Blue_Crash = b;
        Red_Crash  = r;
        step(1);
        Blue_Crash = 1'b0;
        Red_Crash  = 1'b0;
    endtask

    task automatic new_match();
        Reset_Game = 1'b1;
        step(1);
        Reset_Game = 1'b0;
        Game_State = 3'd2;
        step(2);
    endtask

    // Two frame ticks, observing Reset_Round and the W flags for six cycles.
    task automatic run_hold(input bit use15, output int rr_cnt, output int rr_pos, output int w_pos);
        rr_cnt = 0;
        rr_pos = 0;
        w_pos  = 0;
        for (int i = 1; i <= 6; i++) begin
            frame_tick = (i == 1 || i == 3);
            step(1);
            if (use15 ? rr15 : Reset_Round) begin
                rr_cnt++;
                if (rr_pos == 0) rr_pos = i;
            end
            if ((use15 ? (bw15 || rw15) : (Blue_W || Red_W)) && w_pos == 0) w_pos = i;
        end
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Reset_Game = 1'b0; Game_State = 3'd0;
        frame_tick = 1'b0; Blue_Crash = 1'b0; Red_Crash = 1'b0;
        step(2);
        n_checks++;
        if ({Reset_Round, Blue_W, Red_W, Blue_Score, Red_Score, round_winner} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {Reset_Round, Blue_W, Red_W, Blue_Score, Red_Score, round_winner});
        end
        Reset = 1'b1;
        step(1);
        n_checks++;
        if (Blue_Score !== 4'd0 || round_winner !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: score %0d winner %0d expected 0 0", Blue_Score, round_winner);
        end
    endtask

    task automatic test_red_crash();
        int c, p, w;
        new_match();
        crash(1'b0, 1'b1);
        n_checks++;
        if (Blue_Score !== 4'd1 || Red_Score !== 4'd0) begin
            n_fail++;
            $display("FAIL red_crash_score: got %0d/%0d expected 1/0", Blue_Score, Red_Score);
        end
        n_checks++;
        if (round_winner !== 2'd1) begin
            n_fail++;
            $display("FAIL red_crash_winner: got %0d expected 1", round_winner);
        end
        run_hold(1'b0, c, p, w);
        n_checks++;
        if (c != 1 || p != EXP_POS) begin
            n_fail++;
            $display("FAIL red_crash_pulse: count %0d pos %0d expected 1 %0d", c, p, EXP_POS);
        end
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL red_crash_no_w: w_pos %0d expected 0", w);
        end
    endtask

    task automatic test_draw();
        int c, p, w;
        crash(1'b1, 1'b1);
        n_checks++;
        if (Blue_Score !== 4'd1 || Red_Score !== 4'd0 || round_winner !== 2'd3) begin
            n_fail++;
            $display("FAIL draw_result: got %0d/%0d winner %0d expected 1/0 winner 3",
                     Blue_Score, Red_Score, round_winner);
        end
        run_hold(1'b0, c, p, w);
        n_checks++;
        if (c != 1 || p != EXP_POS) begin
            n_fail++;
            $display("FAIL draw_pulse: count %0d pos %0d expected 1 %0d", c, p, EXP_POS);
        end
    endtask

    task automatic test_blue_crash();
        int c, p, w;
        crash(1'b1, 1'b0);
        n_checks++;
        if (Red_Score !== 4'd1 || Blue_Score !== 4'd1 || round_winner !== 2'd2) begin
            n_fail++;
            $display("FAIL blue_crash_result: got %0d/%0d winner %0d expected 1/1 winner 2",
                     Blue_Score, Red_Score, round_winner);
        end
        run_hold(1'b0, c, p, w);
        n_checks++;
        if (c != 1) begin
            n_fail++;
            $display("FAIL blue_crash_pulse: count %0d expected 1", c);
        end
    endtask

    task automatic test_match();
        int c, p, w;
        new_match();
        for (int k = 0; k < 2; k++) begin
            crash(1'b0, 1'b1);
            run_hold(1'b0, c, p, w);
        end
        crash(1'b0, 1'b1);
        n_checks++;
        if (Blue_Score !== 4'd3) begin
            n_fail++;
            $display("FAIL match_score: got %0d expected 3", Blue_Score);
        end
        run_hold(1'b0, c, p, w);
        n_checks++;
        if (c != 0) begin
            n_fail++;
            $display("FAIL match_no_reset_round: count %0d expected 0", c);
        end
        n_checks++;
        if (w != EXP_POS || Blue_W !== 1'b1 || Red_W !== 1'b0) begin
            n_fail++;
            $display("FAIL match_w_flags: pos %0d blue %b red %b expected %0d 1 0", w, Blue_W, Red_W, EXP_POS);
        end
        crash(1'b0, 1'b1);
        n_checks++;
        if (Blue_Score !== 4'd3 || Blue_W !== 1'b1) begin
            n_fail++;
            $display("FAIL match_done_ignores_crash: score %0d w %b expected 3 1", Blue_Score, Blue_W);
        end
        Game_State = 3'd3;
        step(1);
        n_checks++;
        if (Blue_W !== 1'b0) begin
            n_fail++;
            $display("FAIL match_w_clear: got %b expected 0", Blue_W);
        end
    endtask

    task automatic test_reset_game_hold();
        int c, p, w;
        new_match();
        crash(1'b0, 1'b1);
        Reset_Game = 1'b1;
        frame_tick = 1'b1;
        step(1);
        Reset_Game = 1'b0;
        frame_tick = 1'b0;
        n_checks++;
        if (Blue_Score !== 4'd0 || round_winner !== 2'd0 || Reset_Round !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_game_hold: score %0d winner %0d rr %b expected 0 0 0",
                     Blue_Score, round_winner, Reset_Round);
        end
        run_hold(1'b0, c, p, w);
        n_checks++;
        if (c != 0) begin
            n_fail++;
            $display("FAIL reset_game_no_pulse: count %0d expected 0", c);
        end
    endtask

    task automatic test_async_reset();
        int c, p, w;
        new_match();
        crash(1'b0, 1'b1);
        run_hold(1'b0, c, p, w);
        n_checks++;
        if (Blue_Score !== 4'd1) begin
            n_fail++;
            $display("FAIL async_pre_score: got %0d expected 1", Blue_Score);
        end
        #3;
        Reset     = 1'b0;
        Red_Crash = 1'b1;
        #1;
        n_checks++;
        if ({Reset_Round, Blue_W, Red_W, Blue_Score, Red_Score, round_winner} !== 13'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %b expected all zero",
                     {Reset_Round, Blue_W, Red_W, Blue_Score, Red_Score, round_winner});
        end
        step(1);
        Red_Crash = 1'b0;
        step(1);
        Reset = 1'b1;
        step(3);
        n_checks++;
        if (Blue_Score !== 4'd0 || round_winner !== 2'd0) begin
            n_fail++;
            $display("FAIL async_no_pending_crash: score %0d winner %0d expected 0 0", Blue_Score, round_winner);
        end
    endtask

    task automatic test_paused();
        new_match();
        Game_State = 3'd1;
        for (int i = 0; i < 6; i++) begin
            crash(i[0], ~i[0]);
        end
        n_checks++;
        if (Blue_Score !== 4'd0 || Red_Score !== 4'd0 || round_winner !== 2'd0) begin
            n_fail++;
            $display("FAIL paused_crash: got %0d/%0d winner %0d expected 0/0 winner 0",
                     Blue_Score, Red_Score, round_winner);
        end
    endtask

    task automatic test_leave_round();
        int c, p, w;
        new_match();
        crash(1'b0, 1'b1);
        Game_State = 3'd1;
        run_hold(1'b0, c, p, w);
        n_checks++;
        if (c != 0 || Blue_Score !== 4'd1) begin
            n_fail++;
            $display("FAIL leave_round: pulses %0d score %0d expected 0 1", c, Blue_Score);
        end
    endtask

    task automatic test_saturation();
        int c, p, w;
        Reset_Game = 1'b1;
        step(1);
        Reset_Game = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            Game_State = 3'd2;
            step(2);
            crash(1'b0, 1'b1);
            run_hold(1'b1, c, p, w);
            if (k == 14) begin
                n_checks++;
                if (bs15 !== 4'd14 || c != 1) begin
                    n_fail++;
                    $display("FAIL sat_round14: score %0d pulses %0d expected 14 1", bs15, c);
                end
            end
            if (k == 15) begin
                n_checks++;
                if (bs15 !== 4'd15 || w != EXP_POS || c != 0) begin
                    n_fail++;
                    $display("FAIL sat_round15: score %0d wpos %0d pulses %0d expected 15 %0d 0",
                             bs15, w, c, EXP_POS);
                end
            end
            Game_State = 3'd3;
            step(1);
        end
        n_checks++;
        if (bs15 !== 4'd15 || rs15 !== 4'd0 || win15 !== 2'd1) begin
            n_fail++;
            $display("FAIL sat_round20: got %0d/%0d winner %0d expected 15/0 winner 1", bs15, rs15, win15);
        end
    endtask

    initial begin
        test_reset();
        test_red_crash();
        test_draw();
        test_blue_crash();
        test_match();
        test_reset_game_hold();
        test_async_reset();
        test_paused();
        test_leave_round();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
